// File: rtl/backtrack_push.sv
// Viterbi traceback: walks the backpointer RAM from word N-1 down to word 0,
// pushing one POS tag per cycle so the stack later pops in sentence order.
module backtrack_push #(
    parameter int word_num     = 16,
    parameter int word_num_bit = 4,
    parameter int POS_num      = 11,
    parameter int POS_num_bit  = 4
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [word_num_bit:0]               word_count,
    input  logic [POS_num_bit-1:0]              best_last_POS,
    output logic [word_num_bit+POS_num_bit-1:0] bp_addr,
    output logic                                bp_rd_en,
    input  logic [POS_num_bit-1:0]              bp_data,
    output logic [POS_num_bit-1:0]              POS_Stack,
    output logic                                RW_Stack_POS,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [1:0]                          dbg_state
);

    typedef enum logic [1:0] {IDLE, PUSH, DONE, ERR} state_t;

    localparam logic [word_num_bit:0]   WORD_MAX = (word_num_bit+1)'(word_num);
    localparam logic [POS_num_bit-1:0]  POS_MAX  = POS_num_bit'(POS_num);
    localparam logic [word_num_bit-1:0] IDX_ONE  = word_num_bit'(1);

    state_t                  state, state_nxt;
    logic [word_num_bit-1:0] idx, idx_nxt;
    logic [POS_num_bit-1:0]  cur_pos, pos_nxt;
    logic                    start_legal;

    // Request protocol: start is a single-cycle request that only IDLE
    // accepts; abort is a level that wins over everything at the next edge.
    assign start_legal = (word_count != '0) && (word_count <= WORD_MAX) &&
                         (best_last_POS < POS_MAX);
    assign dbg_state   = state;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            cur_pos <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cur_pos <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        pos_nxt      = cur_pos;
        bp_addr      = '0;
        bp_rd_en     = 1'b0;
        POS_Stack    = '0;
        RW_Stack_POS = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (start_legal) begin
                        idx_nxt   = word_count[word_num_bit-1:0] - IDX_ONE;
                        pos_nxt   = best_last_POS;
                        state_nxt = PUSH;
                    end else begin
                        // Pulse is combinational, so keep it quiet while reset is held.
                        error = reset;
                    end
                end
            end
            PUSH: begin
                busy         = 1'b1;
                RW_Stack_POS = 1'b1;
                POS_Stack    = cur_pos;
                if (idx != '0) begin
                    bp_rd_en  = 1'b1;
                    bp_addr   = {idx, cur_pos};
                    idx_nxt   = idx - IDX_ONE;
                    pos_nxt   = bp_data;
                    state_nxt = (bp_data >= POS_MAX) ? ERR : PUSH;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                busy  = 1'b1;
                error = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = idx;
            pos_nxt   = cur_pos;
        end
    end

endmodule

// File: tb/tb_backtrack_push.sv
// Randomised traceback bench: a behavioural tag-chain model predicts every
// cycle's stack/RAM/status outputs, including abort, reset and bad data.
module tb_backtrack_push;

    typedef struct packed {
        logic       rw;
        logic [3:0] pos;
        logic       rd;
        logic [7:0] addr;
        logic       busy;
        logic       done;
        logic       err;
    } rec_t;

    logic       CLK = 1'b0;
    logic       reset, start, abort;
    logic [4:0] word_count;
    logic [3:0] best_last_POS;
    logic [7:0] bp_addr;
    logic       bp_rd_en;
    logic [3:0] bp_data;
    logic [3:0] POS_Stack;
    logic       RW_Stack_POS, busy, done, error;
    logic [1:0] dbg_state;

    logic [3:0] bp_mem [0:255];
    rec_t       exp_q[$];
    rec_t       idle_r;
    int         checks = 0;
    int         errors = 0;

    backtrack_push dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .word_count(word_count), .best_last_POS(best_last_POS),
        .bp_addr(bp_addr), .bp_rd_en(bp_rd_en), .bp_data(bp_data),
        .POS_Stack(POS_Stack), .RW_Stack_POS(RW_Stack_POS),
        .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Backpointer RAM with combinational read
    assign bp_data = bp_mem[bp_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input rec_t e);
        check_eq({tag, ".rw"},    32'(RW_Stack_POS), 32'(e.rw));
        check_eq({tag, ".pos"},   32'(POS_Stack),    32'(e.pos));
        check_eq({tag, ".rd"},    32'(bp_rd_en),     32'(e.rd));
        check_eq({tag, ".addr"},  32'(bp_addr),      32'(e.addr));
        check_eq({tag, ".busy"},  32'(busy),         32'(e.busy));
        check_eq({tag, ".done"},  32'(done),         32'(e.done));
        check_eq({tag, ".err"},   32'(error),        32'(e.err));
        check_eq({tag, ".state"}, 32'(dbg_state != 2'd0), 32'(e.busy));
    endtask

    // Reference model: follow the tag chain word N-1 -> 0 through the RAM.
    task automatic build_model(input int n, input int best, output bit bad);
        int   w;
        int   tag;
        int   nxt;
        rec_t r;
        exp_q.delete();
        bad = 1'b0;
        w   = n - 1;
        tag = best;
        while (1) begin
            r      = '0;
            r.rw   = 1'b1;
            r.pos  = tag[3:0];
            r.busy = 1'b1;
            if (w > 0) begin
                r.rd   = 1'b1;
                r.addr = {w[3:0], tag[3:0]};
            end
            exp_q.push_back(r);
            if (w == 0) break;
            nxt = int'(bp_mem[{w[3:0], tag[3:0]}]);
            if (nxt >= 11) begin
                bad = 1'b1;
                break;
            end
            tag = nxt;
            w   = w - 1;
        end
        r      = '0;
        r.busy = 1'b1;
        if (bad) r.err = 1'b1;
        else     r.done = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic run_trace(input int n, input int best, input int abort_at,
                             input int rst_at, input bit noise);
        bit   bad;
        bit   stopped;
        int   len;
        int   cut;
        rec_t e;
        build_model(n, best, bad);
        stopped = 1'b0;
        len = exp_q.size() + 2;
        cut = (abort_at > 0) ? abort_at + 1 : ((rst_at > 0) ? rst_at : 100000);
        @(posedge CLK); #1;
        start = 1'b1; word_count = 5'(n); best_last_POS = 4'(best);
        @(negedge CLK);
        check_outputs($sformatf("n%0d.c0", n), idle_r);
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c <= len; c++) begin
            if (c >= cut)                e = idle_r;
            else if (c <= exp_q.size())  e = exp_q[c-1];
            else if (bad)                e = exp_q[exp_q.size()-1];
            else                         e = idle_r;
            abort = (c == abort_at);
            if (rst_at > 0 && c >= rst_at && c < rst_at + 2) reset = 1'b0;
            else                                              reset = 1'b1;
            if (abort || !reset) stopped = 1'b1;
            if (noise && e.busy && $urandom_range(0, 2) == 0) begin
                start         = 1'b1;
                word_count    = 5'($urandom_range(0, 31));
                best_last_POS = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            check_outputs($sformatf("n%0d.c%0d", n, c), e);
            @(posedge CLK); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        if (bad && !stopped) begin
            abort = 1'b1;
            @(negedge CLK);
            check_outputs("err_hold", exp_q[exp_q.size()-1]);
            @(posedge CLK); #1;
            abort = 1'b0;
            @(negedge CLK);
            check_outputs("err_abort", idle_r);
        end
    endtask

    task automatic illegal_start(input int wc, input int best, input bit with_abort);
        rec_t e;
        e     = '0;
        e.err = !with_abort;
        @(posedge CLK); #1;
        start = 1'b1; abort = with_abort; word_count = 5'(wc); best_last_POS = 4'(best);
        @(negedge CLK);
        check_outputs($sformatf("ill_wc%0d_b%0d", wc, best), e);
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        check_outputs($sformatf("ill_after_wc%0d", wc), idle_r);
    endtask

    task automatic fill_valid();
        for (int i = 0; i < 256; i++) bp_mem[i] = 4'($urandom_range(0, 10));
    endtask

    initial begin
        idle_r        = '0;
        reset         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        word_count    = '0;
        best_last_POS = '0;
        for (int i = 0; i < 256; i++) bp_mem[i] = 4'd0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs("in_reset", idle_r);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(negedge CLK);
        check_outputs("after_reset", idle_r);

        // Known chain 7 -> 2 -> 5 -> 0
        bp_mem[{4'd3, 4'd7}] = 4'd2;
        bp_mem[{4'd2, 4'd2}] = 4'd5;
        bp_mem[{4'd1, 4'd5}] = 4'd0;
        run_trace(4, 7, 0, 0, 1'b0);
        run_trace(1, 10, 0, 0, 1'b0);

        illegal_start(0, 3, 1'b0);
        illegal_start(17, 3, 1'b0);
        illegal_start(4, 11, 1'b0);
        illegal_start(4, 3, 1'b1);
        illegal_start(0, 3, 1'b1);

        // Bad backpointer at word 9
        fill_valid();
        for (int p = 0; p < 16; p++) bp_mem[{4'd9, 4'(p)}] = 4'd12;
        run_trace(16, $urandom_range(0, 10), 0, 0, 1'b1);

        fill_valid();
        run_trace(8, 4, 3, 0, 1'b0);
        run_trace(8, 6, 0, 0, 1'b0);
        run_trace(8, 2, 0, 4, 1'b0);
        @(negedge CLK);
        check_outputs("post_reset_idle", idle_r);
        run_trace(16, 10, 0, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            int n;
            int ab;
            int rs;
            for (int i = 0; i < 256; i++)
                bp_mem[i] = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(11, 15))
                                                          : 4'($urandom_range(0, 10));
            n  = $urandom_range(1, 16);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : 0;
            rs = (ab == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, n) : 0;
            run_trace(n, $urandom_range(0, 10), ab, rs, 1'b1);
            if ($urandom_range(0, 3) == 0)
                illegal_start($urandom_range(17, 31), $urandom_range(0, 15), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/backtrack_push.md
BACKTRACK_PUSH -- requirements
Module: backtrack_push

Interface
Parameters (name, default, meaning):
REQ-001 word_num, 16, maximum sentence length in words.
REQ-002 word_num_bit, 4, width of a word index.
REQ-003 POS_num, 11, number of valid POS tags (0..POS_num-1).
REQ-004 POS_num_bit, 4, width of a POS tag.
Ports (name, direction, width, meaning):
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a traceback; sampled only in IDLE.
REQ-008 abort  in  1  cancels a traceback in any state.
REQ-009 word_count  in  word_num_bit+1  sentence length N, legal range 1..word_num; sampled with start.
REQ-010 best_last_POS  in  POS_num_bit  argmax tag of word N-1; sampled with start.
REQ-011 bp_addr  out  word_num_bit+POS_num_bit  backpointer RAM address {word index, POS tag}.
REQ-012 bp_rd_en  out  1  backpointer read strobe.
REQ-013 bp_data  in  POS_num_bit  backpointer RAM data; combinational read, valid in the same cycle as bp_addr.
REQ-014 POS_Stack  out  POS_num_bit  tag pushed to the POS stack.
REQ-015 RW_Stack_POS  out  1  stack direction: 1 = push this cycle, 0 = stack owned by the pop side.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse when all N tags have been pushed.
REQ-018 error  out  1  illegal-input or illegal-data indication.

Function
REQ-019 FSM states are IDLE, PUSH, DONE and ERR; the state register plus idx (word_num_bit) and cur_pos (POS_num_bit) are the only sequential state.
REQ-020 Start acceptance: IDLE with start=1, word_count in 1..word_num and best_last_POS<POS_num loads idx=N-1 and cur_pos=best_last_POS, then enters PUSH.
REQ-021 Illegal start: IDLE with start=1 and word_count=0, word_count>word_num or best_last_POS>=POS_num produces a one-cycle error pulse, no push, and the FSM stays in IDLE.
REQ-022 PUSH, every cycle: RW_Stack_POS=1 and POS_Stack=cur_pos, giving exactly one push per PUSH cycle.
REQ-023 PUSH with idx>0: bp_rd_en=1 and bp_addr={idx,cur_pos}; at the clock edge cur_pos<=bp_data and idx<=idx-1.
REQ-024 PUSH with idx=0: bp_rd_en=0 and the next state is DONE.
REQ-025 Push order: N contiguous PUSH cycles push the tag of word N-1 first and the tag of word 0 last, so the stack pops in sentence order.
REQ-026 Latency: with start sampled at cycle 0, pushes occur at cycles 1..N and done=1 at cycle N+1 only; DONE then returns to IDLE.
REQ-027 Outside PUSH: RW_Stack_POS=0, bp_rd_en=0, and POS_Stack and bp_addr are driven to 0.
REQ-028 Bad backpointer: bp_data>=POS_num in a PUSH cycle with idx>0 still completes the current push, then enters ERR with no further pushes.
REQ-029 ERR holds error=1 and busy=1 until abort or reset; start is ignored while in ERR.
REQ-030 Abort takes priority over every other condition: the next state is IDLE, no push occurs in the cycle after abort is sampled, and done is not pulsed.
REQ-031 Simultaneous start and abort in IDLE: abort wins and nothing is loaded.
REQ-032 start while busy (PUSH, DONE or ERR) is ignored.
REQ-033 Index arithmetic is unsigned; idx never decrements below 0, so no wrap-around.

Reset
REQ-034 reset=0 asynchronously forces state=IDLE, idx=0 and cur_pos=0.
REQ-035 During and after reset, until the next start, all outputs are 0: RW_Stack_POS, POS_Stack, bp_addr, bp_rd_en, busy, done, error.
REQ-036 Reset asserted mid-traceback stops pushing immediately, even mid-cycle, and done is never pulsed for the interrupted traceback.

Verification
REQ-037 N=4, best_last_POS=7, backpointers (3,7)->2, (2,2)->5, (1,5)->0 -> RW_Stack_POS=1 at cycles 1-4, POS_Stack=7,2,5,0, done at cycle 5.
REQ-038 N=1, best_last_POS=10 -> a single push of 10 at cycle 1 with bp_rd_en never asserted, done at cycle 2.
REQ-039 Illegal starts: word_count=0, word_count=17 and best_last_POS=11 -> one-cycle error pulse each, no push, busy stays 0.
REQ-040 N=16 with bp_data=12 returned at idx=9 -> pushes for idx 15..9 (7 pushes), then ERR with error held; abort -> IDLE with error=0.
REQ-041 N=8 with abort at cycle 3 -> pushes at cycles 1-3 only, no done pulse; a new start at cycle 5 is accepted.
REQ-042 N=8 with reset driven low at cycle 4 -> all outputs 0 asynchronously; after release, outputs stay idle until the next start.
